// File: rtl/mem_access_controller.sv
// mem_access_controller: sequences 32-bit pipeline loads/stores onto a 16-bit async SRAM
// as two halfword phases, freezing the pipeline until the word completes.
module mem_access_controller #(
   parameter int DATA_WIDTH      = 32,
   parameter int SRAM_ADDR_WIDTH = 18,
   parameter int BASE_ADDR       = 1024,
   parameter int WAIT_STATES     = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mem_read,
   input  logic                       mem_write,
   input  logic [DATA_WIDTH-1:0]      address,
   input  logic [DATA_WIDTH-1:0]      write_data,
   output logic [DATA_WIDTH-1:0]      read_data,
   output logic                       ready,
   output logic                       freeze,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
   inout  wire  [15:0]                sram_dq,
   output logic                       sram_we_n,
   output logic                       sram_oe_n,
   output logic                       sram_ce_n,
   output logic                       sram_ub_n,
   output logic                       sram_lb_n
);
   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
   localparam logic [2:0] W = 3'(WAIT_STATES);
   state_t state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic wr_q, wr_d;
   logic [DATA_WIDTH-1:0] rd_q, rd_d;
   logic ready_q, ready_d, we_n_q, we_n_d, oe_n_q, oe_n_d, ce_n_q, ce_n_d, dq_en_q, dq_en_d;
   logic [15:0] dq_q, dq_d;
   logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic last, act_d, hi_d, last_d;
   always_comb begin
      last    = cnt_q == W;
      state_d = state_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = '0;
      case (state_q)
         IDLE: begin
            state_d = (mem_read | mem_write) ? LOW : IDLE;
            wr_d    = (mem_read | mem_write) ? mem_write : wr_q;
         end
         LOW: begin
            state_d = last ? HIGH : LOW;
            cnt_d   = last ? 3'd0 : cnt_q + 3'd1;
            rd_d    = (last && !wr_q) ? {rd_q[DATA_WIDTH-1:16], sram_dq} : rd_q;
         end
         HIGH: begin
            state_d = last ? DONE : HIGH;
            cnt_d   = last ? 3'd0 : cnt_q + 3'd1;
            rd_d    = (last && !wr_q) ? {sram_dq, rd_q[15:0]} : rd_q;
         end
         default: state_d = IDLE;
      endcase
      // strobes are registered from the next state so they line up with the phase they belong to
      act_d   = state_d == LOW || state_d == HIGH;
      hi_d    = state_d == HIGH;
      last_d  = cnt_d == W;
      ready_d = state_d == DONE;
      we_n_d  = ~(act_d & wr_d & ~last_d);
      oe_n_d  = ~(act_d & ~wr_d);
      ce_n_d  = ~act_d;
      dq_en_d = act_d & wr_d;
      dq_d    = hi_d ? write_data[31:16] : write_data[15:0];
      addr_d  = act_d ? (SRAM_ADDR_WIDTH'(((address - DATA_WIDTH'(BASE_ADDR)) >> 2) << 1)
                         | SRAM_ADDR_WIDTH'(hi_d)) : '0;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         rd_q    <= '0;
         ready_q <= 1'b0;
         we_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         ce_n_q  <= 1'b1;
         dq_en_q <= 1'b0;
         dq_q    <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         ready_q <= ready_d;
         we_n_q  <= we_n_d;
         oe_n_q  <= oe_n_d;
         ce_n_q  <= ce_n_d;
         dq_en_q <= dq_en_d;
         dq_q    <= dq_d;
         addr_q  <= addr_d;
      end
   end
   assign read_data = rd_q;
   assign ready     = ready_q;
   assign freeze    = (mem_read | mem_write) & ~ready_q;
   assign sram_addr = addr_q;
   assign sram_dq   = dq_en_q ? dq_q : 16'hzzzz;
   assign sram_we_n = we_n_q;
   assign sram_oe_n = oe_n_q;
   assign sram_ce_n = ce_n_q;
   assign sram_ub_n = ce_n_q;
   assign sram_lb_n = ce_n_q;
endmodule

// File: tb/tb_mem_access_controller.sv
// tb_mem_access_controller: table-driven transactions with a read-data scoreboard,
// two instances (one wait state, zero wait states) sharing a single stimulus set.
module tb_mem_access_controller;
   logic clk = 1'b0, rst = 1'b0, mem_read = 1'b0, mem_write = 1'b0, sel = 1'b0;
   logic [31:0] address = '0, write_data = '0;
   logic [31:0] rdata1, rdata0;
   logic ready1, ready0, freeze1, freeze0;
   logic we1, we0, oe1, oe0, ce1, ce0, ub1, ub0, lb1, lb0;
   logic [17:0] addr1, addr0;
   wire [15:0] dq1, dq0;
   logic [15:0] mem [0:(1<<18)-1];
   logic [31:0] sb [$];
   logic [31:0] e;
   int checks = 0, failures = 0;
   typedef struct {logic rd, wr; logic [31:0] a, wd, exp;} vec_t;
   vec_t tbl [9];
   always #5 clk = ~clk;
   mem_access_controller #(.WAIT_STATES(1)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read & ~sel), .mem_write(mem_write & ~sel),
      .address(address), .write_data(write_data), .read_data(rdata1), .ready(ready1),
      .freeze(freeze1), .sram_addr(addr1), .sram_dq(dq1), .sram_we_n(we1), .sram_oe_n(oe1),
      .sram_ce_n(ce1), .sram_ub_n(ub1), .sram_lb_n(lb1));
   mem_access_controller #(.WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst), .mem_read(mem_read & sel), .mem_write(mem_write & sel),
      .address(address), .write_data(write_data), .read_data(rdata0), .ready(ready0),
      .freeze(freeze0), .sram_addr(addr0), .sram_dq(dq0), .sram_we_n(we0), .sram_oe_n(oe0),
      .sram_ce_n(ce0), .sram_ub_n(ub0), .sram_lb_n(lb0));
   assign dq1 = (!ce1 && !oe1) ? mem[addr1] : 16'hzzzz;
   always @(posedge clk) if (!ce1 && !we1) mem[addr1] <= dq1;
   wire [31:0] o_rdata = sel ? rdata0 : rdata1;
   wire        o_ready = sel ? ready0 : ready1;
   wire        o_freeze = sel ? freeze0 : freeze1;
   wire [17:0] o_addr = sel ? addr0 : addr1;
   wire [15:0] o_dq = sel ? dq0 : dq1;
   wire        o_we = sel ? we0 : we1;
   wire        o_oe = sel ? oe0 : oe1;
   wire        o_ce = sel ? ce0 : ce1;
   wire        o_ub = sel ? ub0 : ub1;
   wire        o_lb = sel ? lb0 : lb1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      if (rst && o_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_ready actual=1 required=0 at %0t", $time);
         end else begin
            e = sb.pop_front();
            chk("read_data", o_rdata, e);
         end
      end
   end
   // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the IDLE cycle after DONE.
   task automatic txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd);
      int w = sel ? 0 : 1;
      logic [31:0] idx = (a - 32'd1024) >> 2;
      logic act, hi;
      int j;
      sb.push_back(exp_rd);
      mem_read = rd;
      mem_write = wr;
      address = a;
      write_data = wd;
      for (int k = 0; k <= 2 * w + 3; k++) begin
         @(negedge clk);
         act = k >= 1 && k <= 2 * w + 2;
         hi = k >= w + 2;
         j = hi ? k - w - 2 : k - 1;
         chk("ready", o_ready, k == 2 * w + 3);
         chk("freeze", o_freeze, k <= 2 * w + 2);
         chk("ce_n", o_ce, !act);
         chk("ub_n", o_ub, !act);
         chk("lb_n", o_lb, !act);
         chk("we_n", o_we, !(act && wr && j != w));
         chk("oe_n", o_oe, !(act && !wr));
         if (act) chk("sram_addr", o_addr, 18'((idx << 1) | hi));
         if (act && wr) chk("sram_dq", o_dq, hi ? wd[31:16] : wd[15:0]);
         @(posedge clk);
         #1;
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end
   initial begin
      tbl[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h0};
      tbl[1] = '{1'b1, 1'b0, 32'd1032, 32'h0, 32'hDEADBEEF};
      tbl[2] = '{1'b0, 1'b1, 32'd1024, 32'h12345678, 32'hDEADBEEF};
      tbl[3] = '{1'b1, 1'b0, 32'd1024, 32'h0, 32'h12345678};
      tbl[4] = '{1'b0, 1'b1, 32'd1028, 32'hA5A55A5A, 32'h12345678};
      tbl[5] = '{1'b1, 1'b0, 32'd1028, 32'h0, 32'hA5A55A5A};
      tbl[6] = '{1'b1, 1'b0, 32'd1032, 32'h0, 32'hDEADBEEF};
      tbl[7] = '{1'b0, 1'b1, 32'd1027, 32'h0F0FF0F0, 32'hDEADBEEF};
      tbl[8] = '{1'b1, 1'b0, 32'd1024, 32'h0, 32'h0F0FF0F0};
      mem_write = 1'b1;
      address = 32'd1032;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_we_n", we1, 1);
      chk("rst_oe_n", oe1, 1);
      chk("rst_ce_n", ce1, 1);
      chk("rst_ub_lb", {ub1, lb1}, 2'b11);
      chk("rst_ready", ready1, 0);
      chk("rst_addr", addr1, 0);
      chk("rst_read_data", rdata1, 0);
      chk("rst_ce_n0", ce0, 1);
      mem_write = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      foreach (tbl[i]) txn(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].exp);
      mem_read = 1'b0;
      mem_write = 1'b0;
      @(negedge clk);
      chk("idle_freeze", o_freeze, 0);
      chk("idle_ready", o_ready, 0);
      @(posedge clk);
      #1;
      sel = 1'b1;
      txn(1'b1, 1'b1, 32'd1020, 32'h0BADF00D, 32'h0);
      mem_read = 1'b0;
      mem_write = 1'b0;
      @(posedge clk);
      #1;
      sel = 1'b0;
      mem_write = 1'b1;
      address = 32'd1040;
      write_data = 32'hCAFEBABE;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("abort_in_high_ce_n", ce1, 0);
      chk("abort_in_high_addr", addr1, 18'd9);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_we_n", we1, 1);
      chk("abort_ce_n", ce1, 1);
      chk("abort_ready", ready1, 0);
      chk("abort_read_data", rdata1, 0);
      rst = 1'b1;
      mem_write = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("abort_no_ready", ready1, 0);
      end
      @(posedge clk);
      #1;
      txn(1'b1, 1'b0, 32'd1032, 32'h0, 32'hDEADBEEF);
      mem_read = 1'b0;
      @(posedge clk);
      #1;
      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
